// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ISA opcode/funct
// fields, ALU control words and the ALU op class passed to the ALU decoder.
// Latency: n/a (constants and types only). Backpressure: n/a.
package mc_pkg;

    // FSM state encoding
    localparam logic [3:0] S_RESET   = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXECUTE = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;

    typedef enum logic [3:0] {
        ST_RESET   = S_RESET,
        ST_FETCH   = S_FETCH,
        ST_DECODE  = S_DECODE,
        ST_MEMADR  = S_MEMADR,
        ST_MEMRD   = S_MEMRD,
        ST_MEMWB   = S_MEMWB,
        ST_MEMWR   = S_MEMWR,
        ST_EXECUTE = S_EXECUTE,
        ST_ALUWB   = S_ALUWB,
        ST_BRANCH  = S_BRANCH,
        ST_ADDIEX  = S_ADDIEX,
        ST_ADDIWB  = S_ADDIWB,
        ST_JUMP    = S_JUMP
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU control words
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU op class from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps op class + funct to the 3-bit ALU control word and flags funct legality.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
//
// Ports:
//   i_alu_op        op class from the FSM (add / sub / decode funct)
//   i_funct         instruction funct field
//   o_alu_control   ALU operation select
//   o_funct_legal   funct is one of the supported R-type operations
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_legal
);

    logic [2:0] w_funct_ctrl;

    // Legality depends on funct alone so DECODE can check it while the class is still "add".
    always_comb begin
        w_funct_ctrl  = ALU_ADD;
        o_funct_legal = 1'b1;
        case (i_funct)
            F_ADD:   w_funct_ctrl = ALU_ADD;
            F_SUB:   w_funct_ctrl = ALU_SUB;
            F_AND:   w_funct_ctrl = ALU_AND;
            F_OR:    w_funct_ctrl = ALU_OR;
            F_SLT:   w_funct_ctrl = ALU_SLT;
            default: o_funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = ALU_ADD;
            ALUOP_SUB:   o_alu_control = ALU_SUB;
            ALUOP_FUNCT: o_alu_control = w_funct_ctrl;
            default:     o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Latency: Moore outputs valid in the state's own cycle; CPI lw 5, sw/R/addi 4, beq/j 3, illegal 2.
// Backpressure: none; advances one state per clock, async reset aborts any instruction.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode, funct, zero   IR fields (used in DECODE/EXECUTE) and ALU zero flag (BRANCH)
//   alu_control, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg   datapath selects
//   ir_write, mem_write, reg_write, pc_en   write strobes / PC enable
//   illegal               pulse in DECODE for an unsupported opcode or funct
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_en,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       r_is_lw;        // lw vs sw, captured in DECODE so MEMADR need not look at opcode
    alu_op_t    w_alu_op;
    logic       w_alu_en;       // ALU control is driven only in states that use the ALU
    logic       w_pc_write;
    logic       w_branch;
    logic [2:0] w_dec_ctrl;
    logic       w_funct_legal;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (funct),
        .o_alu_control (w_dec_ctrl),
        .o_funct_legal (w_funct_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
            r_is_lw <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_is_lw <= (opcode == OP_LW);
            end
        end
    end

    always_comb begin
        w_next     = ST_RESET;
        w_alu_op   = ALUOP_ADD;
        w_alu_en   = 1'b0;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_next     = ST_DECODE;
                alu_src_b  = 2'b01;
                w_alu_en   = 1'b1;
                ir_write   = 1'b1;
                w_pc_write = 1'b1;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
                w_alu_en  = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_J:         w_next = ST_JUMP;
                    OP_RTYPE: begin
                        if (w_funct_legal) begin
                            w_next = ST_EXECUTE;
                        end else begin
                            w_next  = ST_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        w_next  = ST_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_next    = r_is_lw ? ST_MEMRD : ST_MEMWR;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_alu_en  = 1'b1;
            end
            ST_MEMRD: begin
                w_next = ST_MEMWB;
                iord   = 1'b1;
            end
            ST_MEMWB: begin
                w_next     = ST_FETCH;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                w_next    = ST_FETCH;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                w_next    = ST_ALUWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                w_alu_op  = ALUOP_FUNCT;
                w_alu_en  = 1'b1;
            end
            ST_ALUWB: begin
                w_next    = ST_FETCH;
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                w_next    = ST_FETCH;
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                w_alu_en  = 1'b1;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            ST_ADDIEX: begin
                w_next    = ST_ADDIWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_alu_en  = 1'b1;
            end
            ST_ADDIWB: begin
                w_next    = ST_FETCH;
                reg_write = 1'b1;
            end
            ST_JUMP: begin
                w_next     = ST_FETCH;
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase
    end

    // Non-ALU states leave the control word at 000 rather than a stale op.
    assign alu_control = w_alu_en ? w_dec_ctrl : 3'b000;
    // zero must settle within the BRANCH cycle for the conditional PC update.
    assign pc_en       = w_pc_write | (w_branch & zero);

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed reset/instruction scenarios plus random instruction streams.
// Latency: one check per clock cycle, sampled mid-cycle on the falling edge.
// Backpressure: n/a.
module tb_mc_control;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       pc_en;
        logic       illegal;
    } outs_t;

    typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_J, C_BAD} cls_t;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal;

    int checks   = 0;
    int failures = 0;

    mc_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .iord        (iord),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .pc_en       (pc_en),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t observed();
        outs_t o;
        o = '{alu_control, alu_src_a, alu_src_b, pc_src, iord, ir_write,
              mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal};
        return o;
    endfunction

    // Instruction length in cycles, FETCH inclusive.
    function automatic int cpi(cls_t c);
        case (c)
            C_LW:                  return 5;
            C_SW, C_R, C_ADDI:     return 4;
            C_BEQ, C_J:            return 3;
            default:               return 2;
        endcase
    endfunction

    // R-type ALU operation by funct mnemonic; returns 1 when funct is supported.
    function automatic bit r_alu(input logic [5:0] f, output logic [2:0] ctl);
        ctl = 3'b010;
        case (f)
            6'b100000: begin ctl = 3'b010; return 1'b1; end  // add
            6'b100010: begin ctl = 3'b110; return 1'b1; end  // sub
            6'b100100: begin ctl = 3'b000; return 1'b1; end  // and
            6'b100101: begin ctl = 3'b001; return 1'b1; end  // or
            6'b101010: begin ctl = 3'b111; return 1'b1; end  // slt
            default:   return 1'b0;
        endcase
    endfunction

    // Expected controls for cycle c of an instruction of class cl.
    function automatic outs_t expect_outs(cls_t cl, int c, logic z, logic [5:0] f);
        outs_t e;
        logic [2:0] rctl;
        bit ok;
        e  = '0;
        ok = r_alu(f, rctl);
        if (c == 0) begin
            e.alu_control = 3'b010; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_en = 1;
        end else if (c == 1) begin
            e.alu_control = 3'b010; e.alu_src_b = 2'b11; e.illegal = (cl == C_BAD);
        end else begin
            case (cl)
                C_LW: begin
                    if (c == 2) begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
                    if (c == 3) e.iord = 1;
                    if (c == 4) begin e.mem_to_reg = 1; e.reg_write = 1; end
                end
                C_SW: begin
                    if (c == 2) begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
                    if (c == 3) begin e.iord = 1; e.mem_write = 1; end
                end
                C_R: begin
                    if (c == 2) begin e.alu_src_a = 1; e.alu_control = rctl; end
                    if (c == 3) begin e.reg_dst = 1; e.reg_write = 1; end
                end
                C_ADDI: begin
                    if (c == 2) begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
                    if (c == 3) e.reg_write = 1;
                end
                C_BEQ: begin
                    e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
                end
                C_J: begin
                    e.pc_src = 2'b10; e.pc_en = 1;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input outs_t exp);
        outs_t got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Caller is at a falling edge with the DUT in FETCH of this instruction.
    task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input cls_t cl, input logic bz, input int stop_at);
        for (int c = 0; c < cpi(cl); c++) begin
            if (c == 0) begin
                opcode = 6'($urandom);      // ignored in FETCH
                funct  = 6'($urandom);
            end else if (c == 1) begin
                opcode = opc;
                funct  = fn;
            end
            zero = (cl == C_BEQ && c == 2) ? bz : 1'($urandom);
            #1;
            check($sformatf("%s_c%0d", name, c), expect_outs(cl, c, zero, fn));
            if (c == stop_at) return;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [5:0] rand_bad_opcode();
        logic [5:0] o;
        do o = 6'($urandom);
        while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
        return o;
    endfunction

    function automatic logic [5:0] rand_bad_funct();
        logic [5:0] f;
        logic [2:0] d;
        do f = 6'($urandom);
        while (r_alu(f, d));
        return f;
    endfunction

    initial begin
        logic [5:0] legal_f [5];
        int k;
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset_n = 1'b0;
        opcode  = '0;
        funct   = '0;
        zero    = 1'b0;

        // Reset held for three cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            zero = 1'($urandom);
            #1;
            check($sformatf("reset_c%0d", i), '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_release", '0);
        @(posedge clk);
        @(negedge clk);

        run_instr("lw",       6'b100011, 6'b000000, C_LW,   1'b0, -1);
        run_instr("r_sub",    6'b000000, 6'b100010, C_R,    1'b0, -1);
        run_instr("beq_taken",6'b000100, 6'b000000, C_BEQ,  1'b1, -1);
        run_instr("beq_not",  6'b000100, 6'b000000, C_BEQ,  1'b0, -1);
        run_instr("bad_op",   6'b111111, 6'b000000, C_BAD,  1'b0, -1);
        run_instr("bad_funct",6'b000000, 6'b000111, C_R == C_R ? C_BAD : C_BAD, 1'b0, -1);
        run_instr("sw",       6'b101011, 6'b000000, C_SW,   1'b0, -1);
        run_instr("addi",     6'b001000, 6'b000000, C_ADDI, 1'b0, -1);
        run_instr("j",        6'b000010, 6'b000000, C_J,    1'b0, -1);

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 7);
            case (k)
                0: run_instr($sformatf("rnd%0d_lw", n),   6'b100011, 6'($urandom), C_LW,   1'b0, -1);
                1: run_instr($sformatf("rnd%0d_sw", n),   6'b101011, 6'($urandom), C_SW,   1'b0, -1);
                2: run_instr($sformatf("rnd%0d_r", n),    6'b000000, legal_f[$urandom_range(0, 4)], C_R, 1'b0, -1);
                3: run_instr($sformatf("rnd%0d_addi", n), 6'b001000, 6'($urandom), C_ADDI, 1'b0, -1);
                4: run_instr($sformatf("rnd%0d_beq", n),  6'b000100, 6'($urandom), C_BEQ,  1'($urandom), -1);
                5: run_instr($sformatf("rnd%0d_j", n),    6'b000010, 6'($urandom), C_J,    1'b0, -1);
                6: run_instr($sformatf("rnd%0d_badop", n), rand_bad_opcode(), 6'($urandom), C_BAD, 1'b0, -1);
                default: run_instr($sformatf("rnd%0d_badfn", n), 6'b000000, rand_bad_funct(), C_BAD, 1'b0, -1);
            endcase
        end

        // Reset pulsed in the middle of MEMWR: outputs collapse without waiting for a clock.
        run_instr("sw_abort", 6'b101011, 6'b000000, C_SW, 1'b0, 3);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_drop", '0);
        @(negedge clk);
        #1;
        check("async_reset_hold", '0);
        reset_n = 1'b1;
        #1;
        check("restart_in_reset", '0);
        @(posedge clk);
        @(negedge clk);
        run_instr("post_reset_lw",   6'b100011, 6'b000000, C_LW,   1'b0, -1);
        run_instr("post_reset_addi", 6'b001000, 6'b000000, C_ADDI, 1'b0, -1);
        #1;
        check("final_fetch", expect_outs(C_J, 0, zero, 6'b000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the single-ALU datapath. Sequences each instruction through fetch/decode/execute/memory/writeback states. Drives datapath mux selects and write strobes. Produces the 3-bit ALU control word consumed by the ALU, and takes back the ALU `zero` flag to resolve branches.

## Interface
Parameters:
- none. Widths are fixed by the ISA.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction register bits [31:26]. Stable from DECODE onward.
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag, same cycle.
- `alu_control` out 3: ALU operation. 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write`, `mem_write`, `reg_write` out 1 each: write strobes.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = memory data.
- `pc_en` out 1: PC write enable.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset:
  - Asynchronous assertion forces RESET, including mid-instruction.
  - RESET drives every output to 0.
  - RESET goes to FETCH on the first edge after release.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for lw (100011) or sw (101011).
  - DECODE → EXECUTE for R-type (000000) with a legal funct.
  - DECODE → BRANCH for beq (000100); DECODE → ADDIEX for addi (001000); DECODE → JUMP for j (000010).
  - DECODE → FETCH for anything else, with `illegal`=1 for that DECODE cycle.
  - MEMADR → MEMRD for lw; MEMADR → MEMWR for sw.
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
- Legal funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Moore outputs by state. Any signal not listed is 0.
  - FETCH: alu_src_b=01, add, ir_write=1, pc_write=1.
  - DECODE: alu_src_b=11, add.
  - MEMADR: alu_src_a=1, alu_src_b=10, add.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct.
  - ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: alu_src_a=1, sub, pc_src=01, branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10, add.
  - ADDIWB: reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- `pc_en` = pc_write | (branch & zero). This is combinational, so `zero` must settle within the BRANCH cycle.
- ALU op class: 00 = add, 01 = sub, 10 = decode funct. The sub-module maps this class to the 3-bit `alu_control`.

## Timing
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Write strobes are high for exactly one cycle per instruction.
  - `ir_write` and `pc_write` in FETCH.
  - `reg_write`, `mem_write` and the jump `pc_en` in their terminal state.
- Outputs depend on state only, except `pc_en`, which also depends on `zero`.
- `opcode` and `funct` are sampled in DECODE and EXECUTE only; they are ignored in FETCH.

## Structure
- Package `mc_pkg` holds:
  - the state encoding (4-bit localparams);
  - opcode and funct constants;
  - ALU control codes and the 2-bit ALU op class.
- Sub-module `alu_decoder`: combinational (alu_op[1:0], funct) → alu_control. It also reports funct legality, which DECODE uses for the illegal check.
- `mc_control` holds the state register, next-state logic, and the output decode.

## Test plan
- Reset held low for 3 cycles, then released:
  - all outputs 0 while reset is low;
  - FETCH one cycle after release, with ir_write=1, pc_en=1, alu_control=010, alu_src_b=01.
- lw (100011): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type sub (funct 100010): alu_control=110 in EXECUTE; reg_dst=1 and reg_write=1 in ALUWB; total 4 cycles.
- beq twice:
  - zero=1 in BRANCH gives pc_en=1, pc_src=01;
  - zero=0 gives pc_en=0;
  - both return to FETCH.
- Illegal input:
  - opcode 111111 gives illegal=1 in DECODE and FETCH on the next cycle;
  - R-type with funct 000111 behaves the same way.
- reset_n pulsed low during MEMWR:
  - outputs drop to 0 asynchronously;
  - mem_write is never asserted afterward;
  - restart goes through RESET then FETCH.
